rc5_sched: RTL and testbench
============================

Name: rc5_sched

Overview:
- Top-level sequencer for the RC5 core.
- Runs the key expander after a key load, then admits cipher block requests.
- Arbitrates the single S-table RAM port between the key expander and the round engine.
- Sits between the host interface and the keyExpander and cipher-engine instances.

Parameters:
- W, 32, word width of S-table data.
- R, 12, rounds; T = 2*(R+1) is the S-table depth (local).
- T_LENGTH, $clog2(2*(R+1)), S-table address width (local).
- CNT_W, 16, width of the processed-block counter.
- TIMEOUT, 1024, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- iKeyLoad  in  1  one-cycle request to (re)expand the key.
- oKeyReady  out  1  a valid expanded key is present.
- iBlkValid  in  1  host requests one block operation.
- oBlkReady  out  1  block request accepted this cycle when iBlkValid is also high.
- oExpStart  out  1  start pulse to the key expander.
- iExpDone  in  1  key expander done (level).
- oCipherStart  out  1  start pulse to the round engine.
- iCipherDone  in  1  round engine done (level).
- iExp_address  in  T_LENGTH  expander S address.
- iExp_we  in  1  expander S write enable.
- iExp_data  in  W  expander S write data.
- iCiph_address  in  T_LENGTH  round-engine S read address.
- oS_address  out  T_LENGTH  muxed S-RAM address.
- oS_we  out  1  muxed S-RAM write enable.
- oS_data  out  W  muxed S-RAM write data.
- oBusy  out  1  state is neither IDLE nor READY.
- oBlkCount  out  CNT_W  number of completed blocks since reset.
- oError  out  1  watchdog tripped (sticky).

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, every output 0, pending flag 0, counters 0.
- States and transitions:
  - IDLE: on iKeyLoad -> EXP_START.
  - EXP_START: oExpStart=1 for exactly 1 cycle -> EXP_WAIT.
  - EXP_WAIT: when iExpDone=1 -> READY; oKeyReady rises the cycle after iExpDone is sampled.
  - READY: iKeyLoad -> EXP_START, and oKeyReady drops the next cycle. Otherwise, iBlkValid & oBlkReady -> CIPH_START.
  - CIPH_START: oCipherStart=1 for 1 cycle -> CIPH_WAIT.
  - CIPH_WAIT: when iCipherDone=1, oBlkCount increments (wraps 2^CNT_W-1 -> 0). Then -> EXP_START if pending is set (pending cleared, oKeyReady dropped), else -> READY.
- oBlkReady is combinational: (state==READY) & !iKeyLoad & !pending.
- Simultaneous iKeyLoad and iBlkValid in READY: the key load wins; the block is not accepted.
- iKeyLoad during CIPH_START or CIPH_WAIT sets pending. The current block finishes with the old key. Multiple loads collapse into one.
- iKeyLoad during EXP_START or EXP_WAIT is ignored; the expansion is not restarted.
- S-port ownership:
  - Expander owns the port in EXP_START/EXP_WAIT: oS_address=iExp_address, oS_we=iExp_we, oS_data=iExp_data.
  - Round engine owns it in CIPH_START/CIPH_WAIT: oS_address=iCiph_address, oS_we=0, oS_data=0.
  - In any other state: all three are 0.
  - The mux is combinational, with zero added latency.
- iBlkValid while oKeyReady=0 is never accepted. The host holds the request or drops it; nothing is queued.
- Done inputs sampled in a non-wait state are ignored.

Optional Feature:
- Macro RC5_SCHED_WATCHDOG_EN.
- When defined:
  - A counter runs in EXP_WAIT/CIPH_WAIT and clears on every state change.
  - When it reaches TIMEOUT: state -> IDLE, oKeyReady=0, pending=0, oError=1.
  - oError clears on the next iKeyLoad.
- When undefined: no counter; oError is tied 0; the wait states wait indefinitely.

Decomposition:
- Package rc5_pkg holds:
  - the state enum (IDLE, EXP_START, EXP_WAIT, READY, CIPH_START, CIPH_WAIT);
  - the T and T_LENGTH derivation from R;
  - the default QW/PW constants shared with the expander.
- One natural sub-module: rc5_s_port_mux (the combinational ownership mux, driven by a 2-bit owner code).

Test Plan:
- Key expansion handshake: reset, iKeyLoad pulse, iExpDone after 78 cycles -> oExpStart high for exactly 1 cycle, oKeyReady=1 one cycle after iExpDone, oBusy low.
- Normal block: after key ready, iBlkValid=1 -> oBlkReady=1 and oCipherStart pulses. Drive iCipherDone -> oBlkCount=1; during the wait oS_we=0 and oS_address tracks iCiph_address=5.
- Key load during a block: iKeyLoad twice during CIPH_WAIT -> no restart, exactly one oExpStart after iCipherDone, and the count still increments.
- Simultaneous requests: iKeyLoad=1 with iBlkValid=1 in READY -> oBlkReady=0 and the next state is EXP_START. Separately, force oBlkCount to 16'hFFFF and complete one block -> 0.
- Asynchronous reset: assert rst low mid-EXP_WAIT -> all outputs 0 immediately, oKeyReady=0, and a block request after release is refused.
- Watchdog (RC5_SCHED_WATCHDOG_EN, TIMEOUT=16): never assert iExpDone -> oError=1 after 16 wait cycles, state IDLE; the next iKeyLoad clears oError.

Source files
------------

// File: rtl/rc5_pkg.sv
// Shared types and constants for the RC5 core: scheduler states, S-port owner codes,
// S-table geometry helpers and the magic constants used by the key expander.
package rc5_pkg;

  localparam logic [31:0] PW = 32'hB7E1_5163;
  localparam logic [31:0] QW = 32'h9E37_79B9;

  typedef enum logic [2:0] {
    StIdle,
    StExpStart,
    StExpWait,
    StReady,
    StCiphStart,
    StCiphWait
  } rc5State_e;

  typedef enum logic [1:0] {
    OwnNone,
    OwnExp,
    OwnCiph
  } sOwner_e;

  function automatic int unsigned tDepth(input int unsigned r);
    return 2 * (r + 1);
  endfunction

  function automatic int unsigned tLength(input int unsigned r);
    return $clog2(2 * (r + 1));
  endfunction

endpackage

// File: rtl/rc5_sched_if.sv
// Host-side handshake and status bundle of the RC5 scheduler.
interface rc5_sched_if #(
  parameter int unsigned CNT_W = 16
);

  logic             iKeyLoad;
  logic             oKeyReady;
  logic             iBlkValid;
  logic             oBlkReady;
  logic             oBusy;
  logic [CNT_W-1:0] oBlkCount;
  logic             oError;

  modport slave (
    input  iKeyLoad,
    input  iBlkValid,
    output oKeyReady,
    output oBlkReady,
    output oBusy,
    output oBlkCount,
    output oError
  );

  modport master (
    output iKeyLoad,
    output iBlkValid,
    input  oKeyReady,
    input  oBlkReady,
    input  oBusy,
    input  oBlkCount,
    input  oError
  );

endinterface

// File: rtl/rc5_s_port_mux.sv
// Combinational S-table port mux: the owner code selects expander, round engine or nobody.
module rc5_s_port_mux
  import rc5_pkg::*;
#(
  parameter int unsigned W  = 32,
  parameter int unsigned AW = 5
) (
  input  sOwner_e         owner,
  input  logic [AW-1:0]   expAddress,
  input  logic            expWe,
  input  logic [W-1:0]    expData,
  input  logic [AW-1:0]   ciphAddress,
  output logic [AW-1:0]   sAddress,
  output logic            sWe,
  output logic [W-1:0]    sData
);

  always_comb begin
    sAddress = '0;
    sWe      = 1'b0;
    sData    = '0;
    case (owner)
      OwnExp: begin
        sAddress = expAddress;
        sWe      = expWe;
        sData    = expData;
      end
      // Round engine only reads S; write path stays quiet.
      OwnCiph: sAddress = ciphAddress;
      default: ;
    endcase
  end

endmodule

// File: rtl/rc5_sched.sv
// RC5 top-level sequencer: key expansion, block admission and S-port arbitration.
// Optional watchdog enabled by defining RC5_SCHED_WATCHDOG_EN.
module rc5_sched
  import rc5_pkg::*;
#(
  parameter int unsigned W       = 32,
  parameter int unsigned R       = 12,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 1024,
  localparam int unsigned T_LENGTH = tLength(R)
) (
  input  logic                clk,
  input  logic                rst,
  rc5_sched_if.slave          host,
  output logic                oExpStart,
  input  logic                iExpDone,
  output logic                oCipherStart,
  input  logic                iCipherDone,
  input  logic [T_LENGTH-1:0] iExp_address,
  input  logic                iExp_we,
  input  logic [W-1:0]        iExp_data,
  input  logic [T_LENGTH-1:0] iCiph_address,
  output logic [T_LENGTH-1:0] oS_address,
  output logic                oS_we,
  output logic [W-1:0]        oS_data
);

  rc5State_e        stateQ, stateD;
  logic             pendingQ, pendingD;
  logic [CNT_W-1:0] blkCntQ, blkCntD;
  logic             blkReady;
  sOwner_e          owner;

  assign blkReady = (stateQ == StReady) && !host.iKeyLoad && !pendingQ;

`ifdef RC5_SCHED_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wdQ, wdD;
  logic            errQ, errD;
`endif

  always_comb begin
    stateD   = stateQ;
    pendingD = pendingQ;
    blkCntD  = blkCntQ;
    unique case (stateQ)
      StIdle:      if (host.iKeyLoad) stateD = StExpStart;
      StExpStart:  stateD = StExpWait;
      StExpWait:   if (iExpDone) stateD = StReady;
      StReady: begin
        if (host.iKeyLoad) begin
          stateD = StExpStart;
        end else if (host.iBlkValid && blkReady) begin
          stateD = StCiphStart;
        end
      end
      StCiphStart: begin
        if (host.iKeyLoad) pendingD = 1'b1;
        stateD = StCiphWait;
      end
      StCiphWait: begin
        if (host.iKeyLoad) pendingD = 1'b1;
        if (iCipherDone) begin
          blkCntD = blkCntQ + CNT_W'(1);
          // A load arriving with done must not be lost: READY would never see it.
          if (pendingQ || host.iKeyLoad) begin
            stateD   = StExpStart;
            pendingD = 1'b0;
          end else begin
            stateD = StReady;
          end
        end
      end
      default: stateD = StIdle;
    endcase

`ifdef RC5_SCHED_WATCHDOG_EN
    errD = errQ;
    wdD  = '0;
    if (host.iKeyLoad) errD = 1'b0;
    if ((stateD == stateQ) && ((stateQ == StExpWait) || (stateQ == StCiphWait))) begin
      if (wdQ == WD_W'(TIMEOUT - 1)) begin
        stateD   = StIdle;
        pendingD = 1'b0;
        errD     = 1'b1;
      end else begin
        wdD = wdQ + WD_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ   <= StIdle;
      pendingQ <= 1'b0;
      blkCntQ  <= '0;
    end else begin
      stateQ   <= stateD;
      pendingQ <= pendingD;
      blkCntQ  <= blkCntD;
    end
  end

`ifdef RC5_SCHED_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdQ  <= '0;
      errQ <= 1'b0;
    end else begin
      wdQ  <= wdD;
      errQ <= errD;
    end
  end
  assign host.oError = errQ;
`else
  assign host.oError = 1'b0;
`endif

  always_comb begin
    owner = OwnNone;
    unique case (stateQ)
      StExpStart, StExpWait:   owner = OwnExp;
      StCiphStart, StCiphWait: owner = OwnCiph;
      default:                 owner = OwnNone;
    endcase
  end

  assign oExpStart      = (stateQ == StExpStart);
  assign oCipherStart   = (stateQ == StCiphStart);
  // Key stays valid while a block runs on it.
  assign host.oKeyReady = (stateQ == StReady) || (stateQ == StCiphStart) ||
                          (stateQ == StCiphWait);
  assign host.oBlkReady = blkReady;
  assign host.oBusy     = (stateQ != StIdle) && (stateQ != StReady);
  assign host.oBlkCount = blkCntQ;

  rc5_s_port_mux #(
    .W  (W),
    .AW (T_LENGTH)
  ) u_s_port_mux (
    .owner       (owner),
    .expAddress  (iExp_address),
    .expWe       (iExp_we),
    .expData     (iExp_data),
    .ciphAddress (iCiph_address),
    .sAddress    (oS_address),
    .sWe         (oS_we),
    .sData       (oS_data)
  );

endmodule

// File: tb/tb_rc5_sched.sv
// Directed self-checking bench for rc5_sched; covers the watchdog when RC5_SCHED_WATCHDOG_EN is set.
module tb_rc5_sched;
  import rc5_pkg::*;

  localparam int unsigned AW = tLength(12);
`ifdef RC5_SCHED_WATCHDOG_EN
  localparam int unsigned TO = 16;
`else
  localparam int unsigned TO = 1024;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          oExpStart, iExpDone, oCipherStart, iCipherDone;
  logic [AW-1:0] iExp_address, iCiph_address, oS_address;
  logic          iExp_we, oS_we;
  logic [31:0]   iExp_data, oS_data;
  int            total = 0;
  int            bad = 0;
  int            pulses;

  rc5_sched_if #(.CNT_W(16)) host ();

  rc5_sched #(
    .W       (32),
    .R       (12),
    .CNT_W   (16),
    .TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .host          (host),
    .oExpStart     (oExpStart),
    .iExpDone      (iExpDone),
    .oCipherStart  (oCipherStart),
    .iCipherDone   (iCipherDone),
    .iExp_address  (iExp_address),
    .iExp_we       (iExp_we),
    .iExp_data     (iExp_data),
    .iCiph_address (iCiph_address),
    .oS_address    (oS_address),
    .oS_we         (oS_we),
    .oS_data       (oS_data)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Starts at a negedge in READY; leaves the DUT back in READY with one more block counted.
  task automatic runBlock(input string tag);
    host.iBlkValid = 1'b1;
    #1 checkVal({tag, " blkReady"}, 32'(host.oBlkReady), 32'd1);
    tick();
    host.iBlkValid = 1'b0;
    checkVal({tag, " cipherStart"}, 32'(oCipherStart), 32'd1);
    checkVal({tag, " sDataZero"}, oS_data, 32'd0);
    tick();
    checkVal({tag, " cipherStartOnce"}, 32'(oCipherStart), 32'd0);
    checkVal({tag, " sAddr"}, 32'(oS_address), 32'd5);
    checkVal({tag, " sWe"}, 32'(oS_we), 32'd0);
    repeat (3) tick();
    iCipherDone = 1'b1;
    tick();
    iCipherDone = 1'b0;
    checkVal({tag, " backReady"}, 32'(host.oBusy), 32'd0);
  endtask

  initial begin
    host.iKeyLoad  = 1'b0;
    host.iBlkValid = 1'b0;
    iExpDone       = 1'b0;
    iCipherDone    = 1'b0;
    iExp_address   = AW'(7);
    iExp_we        = 1'b1;
    iExp_data      = 32'hA5A5_0001;
    iCiph_address  = AW'(5);

    #12;
    checkVal("rst keyReady", 32'(host.oKeyReady), 32'd0);
    checkVal("rst busy", 32'(host.oBusy), 32'd0);
    checkVal("rst count", 32'(host.oBlkCount), 32'd0);
    checkVal("rst sAddr", 32'(oS_address), 32'd0);
    checkVal("rst sWe", 32'(oS_we), 32'd0);
    checkVal("rst error", 32'(host.oError), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Key expansion handshake with done after 78 wait cycles.
    host.iKeyLoad = 1'b1;
    tick();
    host.iKeyLoad = 1'b0;
    checkVal("exp start", 32'(oExpStart), 32'd1);
    checkVal("exp busy", 32'(host.oBusy), 32'd1);
    checkVal("exp sAddr", 32'(oS_address), 32'd7);
    checkVal("exp sWe", 32'(oS_we), 32'd1);
    checkVal("exp sData", oS_data, 32'hA5A5_0001);
    pulses = 1;
    for (int i = 0; i < 78; i++) begin
      tick();
      pulses += int'(oExpStart);
    end
    checkVal("exp keyNotReady", 32'(host.oKeyReady), 32'd0);
    iExpDone = 1'b1;
    tick();
    iExpDone = 1'b0;
    checkVal("exp keyReady", 32'(host.oKeyReady), 32'd1);
    checkVal("exp idleBusy", 32'(host.oBusy), 32'd0);
    checkVal("exp onePulse", 32'(pulses), 32'd1);
    checkVal("ready sWe", 32'(oS_we), 32'd0);

    // Normal block.
    runBlock("blk1");
    checkVal("blk1 count", 32'(host.oBlkCount), 32'd1);

    // Two key loads during a block collapse into one re-expansion afterwards.
    host.iBlkValid = 1'b1;
    tick();
    host.iBlkValid = 1'b0;
    tick();
    pulses = 0;
    for (int i = 0; i < 2; i++) begin
      host.iKeyLoad = 1'b1;
      tick();
      host.iKeyLoad = 1'b0;
      pulses += int'(oExpStart);
      tick();
      pulses += int'(oExpStart);
    end
    checkVal("pend noRestart", 32'(pulses), 32'd0);
    checkVal("pend keyStill", 32'(host.oKeyReady), 32'd1);
    iCipherDone = 1'b1;
    tick();
    iCipherDone = 1'b0;
    checkVal("pend expStart", 32'(oExpStart), 32'd1);
    checkVal("pend keyDrop", 32'(host.oKeyReady), 32'd0);
    checkVal("pend count", 32'(host.oBlkCount), 32'd2);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      pulses += int'(oExpStart);
    end
    checkVal("pend singleExp", 32'(pulses), 32'd0);
    iExpDone = 1'b1;
    tick();
    iExpDone = 1'b0;
    checkVal("pend cleared", 32'(host.oBlkReady), 32'd1);

    // Simultaneous load and block: load wins.
    host.iKeyLoad  = 1'b1;
    host.iBlkValid = 1'b1;
    #1 checkVal("sim blkReady", 32'(host.oBlkReady), 32'd0);
    tick();
    host.iKeyLoad  = 1'b0;
    host.iBlkValid = 1'b0;
    checkVal("sim expStart", 32'(oExpStart), 32'd1);
    checkVal("sim noCipher", 32'(oCipherStart), 32'd0);
    checkVal("sim keyDrop", 32'(host.oKeyReady), 32'd0);
    tick();
    host.iKeyLoad = 1'b1;
    tick();
    host.iKeyLoad = 1'b0;
    checkVal("expWait loadIgnored", 32'(oExpStart), 32'd0);
    tick();
    checkVal("expWait stillBusy", 32'(host.oBusy), 32'd1);
    iExpDone = 1'b1;
    tick();
    iExpDone = 1'b0;
    iCipherDone = 1'b1;
    tick();
    iCipherDone = 1'b0;
    checkVal("stray done", 32'(host.oBlkCount), 32'd2);

    // Counter wrap.
    force dut.blkCntQ = 16'hFFFF;
    tick();
    release dut.blkCntQ;
    tick();
    checkVal("wrap preset", 32'(host.oBlkCount), 32'h0000_FFFF);
    runBlock("wrap");
    checkVal("wrap count", 32'(host.oBlkCount), 32'd0);
    runBlock("post");
    checkVal("post count", 32'(host.oBlkCount), 32'd1);

    // Asynchronous reset in the middle of EXP_WAIT.
    host.iKeyLoad = 1'b1;
    tick();
    host.iKeyLoad = 1'b0;
    repeat (2) tick();
    #2 rst = 1'b0;
    #1;
    checkVal("arst busy", 32'(host.oBusy), 32'd0);
    checkVal("arst keyReady", 32'(host.oKeyReady), 32'd0);
    checkVal("arst sWe", 32'(oS_we), 32'd0);
    checkVal("arst sAddr", 32'(oS_address), 32'd0);
    checkVal("arst count", 32'(host.oBlkCount), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    host.iBlkValid = 1'b1;
    #1 checkVal("arst refuse", 32'(host.oBlkReady), 32'd0);
    tick();
    host.iBlkValid = 1'b0;
    checkVal("arst noCipher", 32'(oCipherStart), 32'd0);
    checkVal("arst idle", 32'(host.oBusy), 32'd0);

`ifdef RC5_SCHED_WATCHDOG_EN
    host.iKeyLoad = 1'b1;
    tick();
    host.iKeyLoad = 1'b0;
    tick();
    repeat (15) tick();
    checkVal("wd notYet", 32'(host.oError), 32'd0);
    checkVal("wd stillWait", 32'(host.oBusy), 32'd1);
    tick();
    checkVal("wd error", 32'(host.oError), 32'd1);
    checkVal("wd idle", 32'(host.oBusy), 32'd0);
    checkVal("wd keyReady", 32'(host.oKeyReady), 32'd0);
    host.iKeyLoad = 1'b1;
    tick();
    host.iKeyLoad = 1'b0;
    checkVal("wd errClear", 32'(host.oError), 32'd0);
    checkVal("wd restart", 32'(oExpStart), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
